seg_scan_mux: RTL and testbench

- Time-multiplexed driver for a multi-digit, active-low, common-anode seven-segment display.
- Scans NUM_DIGITS pre-decoded segment patterns onto one shared segment bus, one digit slot at a time.
- One digit slot is the AM/PM indicator. It is shown only in the configured clock mode and blanked in all other modes.
- Sits between the time/alarm/stopwatch datapath and the board pins. It replaces the single-digit, purely mode-gated AM/PM output driver.

---
 rtl/seg_scan_mux.sv | 100 ++++++++++
 tb/tb_seg_scan_mux.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: multiplexed active-low common-anode 7-segment scanner with a mode-gated AM/PM slot.
// Optional blink of masked slots (field-being-set indication) is enabled with `define SEG_SCAN_BLINK_EN.
module seg_scan_mux #(
    parameter int                NUM_DIGITS = 4,
    parameter int                SCAN_DIV   = 100000,
    parameter int                MODE_W     = 2,
    parameter int                AP_DIGIT   = 3,
    parameter logic [MODE_W-1:0] AP_MODE    = 2'b01
`ifdef SEG_SCAN_BLINK_EN
    ,
    parameter int                BLINK_DIV  = 256
`endif
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [MODE_W-1:0]               mode,
    input  logic [7*NUM_DIGITS-1:0]         seg_in,
    input  logic [NUM_DIGITS-1:0]           digit_en,
    input  logic                            ap_i,
`ifdef SEG_SCAN_BLINK_EN
    input  logic [NUM_DIGITS-1:0]           blink_mask,
`endif
    output logic [NUM_DIGITS-1:0]           an_o,
    output logic [6:0]                      seg_o,
    output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [6:0] SEG_A   = 7'b0001000;
    localparam logic [6:0] SEG_P   = 7'b0001100;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic [6:0]            slot_seg;
    logic                  tick, is_ap, lit, blink_off;

`ifdef SEG_SCAN_BLINK_EN
    localparam int FW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;

    logic [FW-1:0] frame_q, frame_d;
    logic          phase_q, phase_d, frame_end, frame_wrap;

    // Frame counter advances once per full scan; its wrap flips the blink phase
    always_comb begin
        frame_end  = tick && idx_q == IW'(NUM_DIGITS-1);
        frame_wrap = frame_q == FW'(BLINK_DIV-1);
        frame_d    = frame_end ? (frame_wrap ? '0 : frame_q + 1'b1) : frame_q;
        phase_d    = (frame_end && frame_wrap) ? ~phase_q : phase_q;
    end

    // Blink state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_q <= '0;
            phase_q <= 1'b0;
        end else begin
            frame_q <= frame_d;
            phase_q <= phase_d;
        end
    end

    assign blink_off = phase_q & blink_mask[idx_q];
`else
    assign blink_off = 1'b0;
`endif

    // Prescaler/index next state and the output pattern for the current slot
    always_comb begin
        tick     = presc_q == PW'(SCAN_DIV-1);
        presc_d  = tick ? '0 : presc_q + 1'b1;
        idx_d    = tick ? (idx_q == IW'(NUM_DIGITS-1) ? '0 : idx_q + 1'b1) : idx_q;
        is_ap    = idx_q == IW'(AP_DIGIT);
        slot_seg = is_ap ? (ap_i ? SEG_P : SEG_A) : seg_in[7*idx_q +: 7];
        lit      = !tick && digit_en[idx_q] && !blink_off && (!is_ap || mode == AP_MODE);
        an_d     = lit ? ~(NUM_DIGITS'(1) << idx_q) : '1;
        seg_d    = lit ? slot_seg : SEG_OFF;
    end

    // Scan state and registered outputs; loading blank on tick gives one dark cycle per slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= '0;
            an_q    <= '1;
            seg_q   <= SEG_OFF;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign an_o      = an_q;
    assign seg_o     = seg_q;
    assign digit_idx = idx_q;
endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: directed scoreboard bench for seg_scan_mux (4 digits, 4 clks per slot).
module tb_seg_scan_mux;
    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic [1:0] idx;
        int         n;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  mode = 2'b00;
    logic [27:0] seg_in = '0;
    logic [3:0]  digit_en = 4'b0000;
    logic        ap_i = 1'b0;
    logic [3:0]  an_o;
    logic [6:0]  seg_o;
    logic [1:0]  digit_idx;

    exp_t       q[$];
    int         tests = 0;
    int         fails = 0;
    int         n = 0;
    bit         in_rst = 1'b1;
    logic [3:0] lit = 4'b0000;
    logic [6:0] segtab [4];

    seg_scan_mux #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut (
        .clk(clk),
        .reset(reset),
        .mode(mode),
        .seg_in(seg_in),
        .digit_en(digit_en),
        .ap_i(ap_i),
`ifdef SEG_SCAN_BLINK_EN
        .blink_mask(4'b0000),
`endif
        .an_o(an_o),
        .seg_o(seg_o),
        .digit_idx(digit_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] an_of(input int s);
        case (s)
            0:       return 4'b1110;
            1:       return 4'b1101;
            2:       return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    // One clock of stimulus: push what the outputs must show after the coming posedge
    task automatic step(input bit do_rst);
        exp_t e;
        e.an  = 4'b1111;
        e.seg = 7'h7F;
        e.idx = 2'd0;
        if (!do_rst && !in_rst) begin
            n++;
            e.idx = 2'((n / 4) % 4);
            if (n % 4 != 0 && lit[(n / 4) % 4]) begin
                e.an  = an_of((n / 4) % 4);
                e.seg = segtab[(n / 4) % 4];
            end
        end
        e.n = n;
        q.push_back(e);
        @(posedge clk);
        if (do_rst) begin
            #1 reset = 1'b1;
            in_rst = 1'b1;
        end
        @(negedge clk);
    endtask

    // Monitor: compare every sampled output against the head of the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                tests++;
                if (an_o !== e.an || seg_o !== e.seg || digit_idx !== e.idx) begin
                    fails++;
                    $display("FAIL scan n=%0d: got an_o=%b seg_o=%h idx=%0d, expected an_o=%b seg_o=%h idx=%0d",
                             e.n, an_o, seg_o, digit_idx, e.an, e.seg, e.idx);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        segtab = '{7'h7F, 7'h7F, 7'h7F, 7'h7F};
        @(negedge clk);
        repeat (3) step(1'b0);
        // Data slots, mode 00: AM/PM slot blank
        seg_in   = {7'h30, 7'h24, 7'h79, 7'h40};
        digit_en = 4'b1111;
        lit      = 4'b0111;
        segtab   = '{7'h40, 7'h79, 7'h24, 7'h7F};
        reset    = 1'b0;
        in_rst   = 1'b0;
        n        = 0;
        repeat (16) step(1'b0);
        // AM shown in AP mode
        mode      = 2'b01;
        lit       = 4'b1111;
        segtab[3] = 7'b0001000;
        repeat (16) step(1'b0);
        // PM, then mode change while slot 3 is lit
        ap_i      = 1'b1;
        segtab[3] = 7'b0001100;
        repeat (30) step(1'b0);
        mode   = 2'b10;
        lit[3] = 1'b0;
        repeat (18) step(1'b0);
        // Disabled slots 0 and 2
        mode      = 2'b01;
        ap_i      = 1'b0;
        digit_en  = 4'b1010;
        lit       = 4'b1010;
        segtab[3] = 7'b0001000;
        repeat (16) step(1'b0);
        // Reset mid-scan while slot 2 is active
        mode      = 2'b00;
        digit_en  = 4'b1111;
        lit       = 4'b0111;
        segtab[3] = 7'h7F;
        repeat (9) step(1'b0);
        step(1'b1);
        repeat (2) step(1'b0);
        reset  = 1'b0;
        in_rst = 1'b0;
        n      = 0;
        repeat (8) step(1'b0);
        repeat (4) begin
            if (q.size() != 0) begin
                @(posedge clk);
                #3;
            end
        end
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
